wb_dispatch_n: RTL

Parametrised Wishbone dispatcher sitting between the single bus requester and up to 2^SEL_W peripheral modules (pcfg, cntr, and future blocks). It decodes the upper address bits into a window index, registers the selected window for the whole transaction, forwards the strobe, data and ack, and acknowledges unmapped windows itself. It also bounds every access with a timeout so a silent module cannot hang the bus, and latches an error record for firmware.

---
 rtl/wb_dispatch_n_pkg.sv | 21 ++
 rtl/wb_dispatch_n_if.sv | 37 +++
 rtl/wb_dispatch_n_timeout_cntr.sv | 27 ++
 rtl/wb_dispatch_n.sv | 128 ++++++++++++
 4 files changed

// File: rtl/wb_dispatch_n_pkg.sv
// Shared definitions for the Wishbone window dispatcher: FSM encoding,
// default timeout and the address-map window indices.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_LOCAL = 2'd2
  } state_t;

  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned SEL_W_DEF   = 3;

  localparam int unsigned PCFG_WIN = 1;
  localparam int unsigned CNTR_WIN = 7;

  // Populated-window mask built from the window indices above.
  localparam logic [(1 << SEL_W_DEF)-1:0] SLV_MASK_DEF =
    ((1 << SEL_W_DEF)'(1) << PCFG_WIN) | ((1 << SEL_W_DEF)'(1) << CNTR_WIN);

endpackage

// File: rtl/wb_dispatch_n_if.sv
// Bus bundle between the requester, the dispatcher and the peripheral windows.
// Handshake: a transfer is requested while cyc&stb are high and completes in
// the cycle ack is high; the requester holds stb/adr/dat stable until that ack.
interface wb_dispatch_n_if #(
  parameter int unsigned ADR_W = 7,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DAT_W = 32
);
  localparam int unsigned NSLV   = 1 << SEL_W;
  localparam int unsigned SADR_W = ADR_W - SEL_W;

  logic                  wb_stb_i;
  logic                  wb_cyc_i;
  logic                  wb_we_i;
  logic [ADR_W-1:0]      wb_adr_i;
  logic [DAT_W-1:0]      wb_dat_i;
  logic [DAT_W-1:0]      wb_dat_o;
  logic                  wb_ack_o;

  logic [NSLV-1:0]       s_stb_o;
  logic                  s_cyc_o;
  logic                  s_we_o;
  logic [SADR_W-1:0]     s_adr_o;
  logic [DAT_W-1:0]      s_dat_o;
  logic [NSLV*DAT_W-1:0] s_dat_i;
  logic [NSLV-1:0]       s_ack_i;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, s_dat_i, s_ack_i,
    output wb_dat_o, wb_ack_o, s_stb_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i, s_dat_i, s_ack_i,
    input  wb_dat_o, wb_ack_o, s_stb_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o
  );
endinterface

// File: rtl/wb_dispatch_n_timeout_cntr.sv
// Clear/enable cycle counter that flags when it sits at TIMEOUT-1.
module wb_timeout_cntr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == TERM);
endmodule

// File: rtl/wb_dispatch_n.sv
// Wishbone dispatcher: decodes the upper address bits into a window, forwards
// the access to populated windows, self-acks unmapped ones and bounds latency.
module wb_dispatch_n
  import wb_pkg::*;
#(
  parameter int unsigned ADR_W   = 7,
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DAT_W   = 32,
  parameter logic [(1 << SEL_W)-1:0] SLV_MASK = SLV_MASK_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  wb_dispatch_n_if.slave    bus,
  input  logic              err_clr_i,
  output logic              err_o,
  output logic [SEL_W-1:0]  err_win_o,
  output state_t            o_dbg_state
);
  localparam int unsigned NSLV = 1 << SEL_W;

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_sel;
  logic             r_err;
  logic [SEL_W-1:0] r_err_win;

  logic             w_req;
  logic [SEL_W-1:0] w_adr_sel;
  logic             w_slv_ack;
  logic [DAT_W-1:0] w_slv_dat;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic             w_tmr_term;
  logic             w_ack;
  logic [DAT_W-1:0] w_dat;
  logic [NSLV-1:0]  w_stb;
  logic             w_tmo;

  assign w_req     = bus.wb_cyc_i & bus.wb_stb_i;
  assign w_adr_sel = bus.wb_adr_i[ADR_W-1 -: SEL_W];
  assign w_slv_ack = bus.s_ack_i[r_sel];
  assign w_slv_dat = bus.s_dat_i[r_sel*DAT_W +: DAT_W];

  // The timer only runs while a forwarded access waits; leaving FWD rearms it.
  assign w_tmr_clr = (r_state != ST_FWD);
  assign w_tmr_en  = (r_state == ST_FWD) & ~w_slv_ack;

  wb_timeout_cntr #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .o_term (w_tmr_term)
  );

  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    w_dat  = '0;
    w_stb  = '0;
    w_tmo  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next = SLV_MASK[w_adr_sel] ? ST_FWD : ST_LOCAL;
        end
      end
      ST_FWD: begin
        if (!bus.wb_cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_slv_ack) begin
          w_stb[r_sel] = bus.wb_stb_i;
          w_ack        = 1'b1;
          w_dat        = w_slv_dat;
          w_next       = ST_IDLE;
        end else if (w_tmr_term) begin
          // Forced completion: strobe withdrawn, zero data returned.
          w_ack  = 1'b1;
          w_tmo  = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_stb[r_sel] = bus.wb_stb_i;
        end
      end
      ST_LOCAL: begin
        w_ack  = bus.wb_cyc_i;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_err     <= 1'b0;
      r_err_win <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_req) begin
        r_sel <= w_adr_sel;
      end
      if (w_tmo && !r_err) begin
        r_err_win <= r_sel;
      end
      // A clear in the same cycle as a timeout leaves the flag low.
      if (err_clr_i) begin
        r_err <= 1'b0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.wb_ack_o = w_ack;
  assign bus.wb_dat_o = w_dat;
  assign bus.s_stb_o  = w_stb;
  assign bus.s_cyc_o  = bus.wb_cyc_i;
  assign bus.s_we_o   = bus.wb_we_i;
  assign bus.s_adr_o  = bus.wb_adr_i[ADR_W-SEL_W-1:0];
  assign bus.s_dat_o  = bus.wb_dat_i;

  assign err_o       = r_err;
  assign err_win_o   = r_err_win;
  assign o_dbg_state = r_state;
endmodule
